// File: rtl/mask_match_sequencer.sv
// mask_match_sequencer: walks the mutual mask (W & A) of one weight/activation
// mask pair from LSB to MSB, emitting up to MAX_NUM_OUTPUT matched positions per
// beat together with their dense indices into the W and A compressed streams.
//
// Handshakes: a transfer happens on a rising clock edge where valid & ready are
// both high. The producer holds valid and data stable until ready is seen;
// ready may depend on valid only through in_ready's last-beat term. out_* are
// registered and held stable while out_valid & !out_ready.
module mask_match_sequencer #(
  parameter int BITMASK_LENGTH = 16,
  parameter int INDEX_BITWIDTH = 5,
  parameter int MAX_NUM_OUTPUT = 2,
  parameter int COUNT_BITWIDTH = 2
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [BITMASK_LENGTH-1:0]                in_maskW,
  input  logic [BITMASK_LENGTH-1:0]                in_maskA,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [COUNT_BITWIDTH-1:0]                out_count,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] out_pos,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] out_idxW,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] out_idxA,
  output logic                                     out_last,
  output logic                                     dbg_state
);

  localparam int LW = INDEX_BITWIDTH * MAX_NUM_OUTPUT;

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t                      r_state;
  logic [BITMASK_LENGTH-1:0]   r_maskW;
  logic [BITMASK_LENGTH-1:0]   r_maskA;
  logic [BITMASK_LENGTH-1:0]   r_rem;
  logic [BITMASK_LENGTH-1:0]   r_emit;
  logic [COUNT_BITWIDTH-1:0]   r_count;
  logic [LW-1:0]               r_pos;
  logic [LW-1:0]               r_idxw;
  logic [LW-1:0]               r_idxa;
  logic                        r_last;

  logic                        w_hs;
  logic                        w_accept;
  state_t                      w_nstate;
  logic [BITMASK_LENGTH-1:0]   w_nw;
  logic [BITMASK_LENGTH-1:0]   w_na;
  logic [BITMASK_LENGTH-1:0]   w_nrem;

  logic [LW-1:0]               w_bpos;
  logic [LW-1:0]               w_bidxw;
  logic [LW-1:0]               w_bidxa;
  logic [BITMASK_LENGTH-1:0]   w_bemit;
  logic [COUNT_BITWIDTH-1:0]   w_bcount;
  logic [INDEX_BITWIDTH-1:0]   w_btotal;
  logic [INDEX_BITWIDTH-1:0]   w_pcw;
  logic [INDEX_BITWIDTH-1:0]   w_pca;
  logic                        w_blast;

  // Handshake decode and next-state values for the latched masks and remaining mask.
  always_comb begin
    w_hs     = (r_state == ST_SCAN) & out_ready;
    in_ready = ~reset & ((r_state == ST_IDLE) | (w_hs & r_last));
    w_accept = in_valid & in_ready;
    w_nstate = r_state;
    w_nw     = r_maskW;
    w_na     = r_maskA;
    w_nrem   = r_rem;
    if (w_accept) begin
      w_nstate = ST_SCAN;
      w_nw     = in_maskW;
      w_na     = in_maskA;
      w_nrem   = in_maskW & in_maskA;
    end else if (w_hs) begin
      w_nrem = r_rem & ~r_emit;
      if (r_last) w_nstate = ST_IDLE;
    end
  end

  // Build the next beat: lowest set bits of the next remaining mask plus running popcounts.
  always_comb begin
    w_bpos   = '0;
    w_bidxw  = '0;
    w_bidxa  = '0;
    w_bemit  = '0;
    w_bcount = '0;
    w_btotal = '0;
    w_pcw    = '0;
    w_pca    = '0;
    for (int i = 0; i < BITMASK_LENGTH; i++) begin
      if (w_nrem[i]) begin
        if (int'(w_bcount) < MAX_NUM_OUTPUT) begin
          w_bpos[int'(w_bcount)*INDEX_BITWIDTH +: INDEX_BITWIDTH]  = INDEX_BITWIDTH'(i);
          w_bidxw[int'(w_bcount)*INDEX_BITWIDTH +: INDEX_BITWIDTH] = w_pcw;
          w_bidxa[int'(w_bcount)*INDEX_BITWIDTH +: INDEX_BITWIDTH] = w_pca;
          w_bemit[i] = 1'b1;
          w_bcount   = w_bcount + COUNT_BITWIDTH'(1);
        end
        w_btotal = w_btotal + INDEX_BITWIDTH'(1);
      end
      w_pcw = w_pcw + INDEX_BITWIDTH'(w_nw[i]);
      w_pca = w_pca + INDEX_BITWIDTH'(w_na[i]);
    end
    w_blast = (int'(w_btotal) <= MAX_NUM_OUTPUT);
  end

  // Sequencer state plus registered beat; beat fields are zero whenever idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_maskW <= '0;
      r_maskA <= '0;
      r_rem   <= '0;
      r_emit  <= '0;
      r_count <= '0;
      r_pos   <= '0;
      r_idxw  <= '0;
      r_idxa  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_maskW <= w_nw;
      r_maskA <= w_na;
      r_rem   <= w_nrem;
      if (w_nstate == ST_SCAN) begin
        r_emit  <= w_bemit;
        r_count <= w_bcount;
        r_pos   <= w_bpos;
        r_idxw  <= w_bidxw;
        r_idxa  <= w_bidxa;
        r_last  <= w_blast;
      end else begin
        r_emit  <= '0;
        r_count <= '0;
        r_pos   <= '0;
        r_idxw  <= '0;
        r_idxa  <= '0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out_valid = (r_state == ST_SCAN);
  assign out_count = r_count;
  assign out_pos   = r_pos;
  assign out_idxW  = r_idxw;
  assign out_idxA  = r_idxa;
  assign out_last  = r_last;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mask_match_sequencer.sv
// Bench for mask_match_sequencer: directed scenarios with hand-derived beats and
// a randomized run checked against a list-of-matches reference model.
module tb_mask_match_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_maskW;
  logic [15:0] in_maskA;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_count;
  logic [9:0]  out_pos;
  logic [9:0]  out_idxW;
  logic [9:0]  out_idxA;
  logic        out_last;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  // {valid, last, count, pos[lane1,lane0], idxW[lane1,lane0], idxA[lane1,lane0]}
  logic [33:0] obs;
  logic [33:0] exp_q[$];

  assign obs = {out_valid, out_last, out_count, out_pos, out_idxW, out_idxA};

  mask_match_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_maskW(in_maskW), .in_maskA(in_maskA), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_pos(out_pos),
    .out_idxW(out_idxW), .out_idxA(out_idxA), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // Clock block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [33:0] mk(logic v, logic l, int c, int p0, int p1,
                                     int w0, int w1, int a0, int a1);
    return {v, l, 2'(c), 5'(p1), 5'(p0), 5'(w1), 5'(w0), 5'(a1), 5'(a0)};
  endfunction

  // Reference model: list the matched positions, chop into groups of two.
  function automatic void push_model(logic [15:0] w, logic [15:0] a);
    int pl[$];
    int pp[2], pw[2], pa[2];
    int k;
    logic [15:0] m;
    for (int i = 0; i < 16; i++) if (w[i] && a[i]) pl.push_back(i);
    if (pl.size() == 0) begin
      exp_q.push_back(mk(1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      for (int b = 0; b < pl.size(); b += 2) begin
        k = (pl.size() - b >= 2) ? 2 : 1;
        for (int j = 0; j < 2; j++) begin
          pp[j] = 0; pw[j] = 0; pa[j] = 0;
          if (j < k) begin
            pp[j] = pl[b+j];
            m = 16'h1 << pp[j];
            m = m - 16'h1;
            pw[j] = $countones(w & m);
            pa[j] = $countones(a & m);
          end
        end
        exp_q.push_back(mk(1'b1, (pl.size() - b) <= 2, k, pp[0], pp[1],
                           pw[0], pw[1], pa[0], pa[1]));
      end
    end
  endfunction

  // Driver: present a pair at the next falling edge (accepted at following rising edge if ready).
  task automatic drive_pair(logic [15:0] w, logic [15:0] a);
    @(negedge clock);
    in_valid = 1'b1;
    in_maskW = w;
    in_maskA = a;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_maskW = '0; in_maskA = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (obs !== 34'h0 || in_ready !== 1'b0 || dbg_state !== 1'b0) begin
      bad++; $display("FAIL reset_hold got obs=%h rdy=%b st=%b exp obs=0 rdy=0 st=0", obs, in_ready, dbg_state);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 34'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release got obs=%h rdy=%b exp obs=0 rdy=1", obs, in_ready);
    end
  endtask

  task automatic test_basic;
    logic [33:0] e;
    // Case 1: four matches over two beats
    drive_pair(16'h8421, 16'hFFFF);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL c1_accept got=%b exp=1", in_ready); end
    @(negedge clock); in_valid = 1'b0;
    e = mk(1, 0, 2, 0, 5, 0, 1, 0, 5);
    total++;
    if (obs !== e) begin bad++; $display("FAIL c1_beat1 got=%h exp=%h", obs, e); end
    @(negedge clock);
    e = mk(1, 1, 2, 10, 15, 2, 3, 10, 15);
    total++;
    if (obs !== e) begin bad++; $display("FAIL c1_beat2 got=%h exp=%h", obs, e); end
    // Case 2: empty mutual mask gives one count=0 last beat
    drive_pair(16'h00FF, 16'hFF00);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL c1_end got=%b exp=0", out_valid); end
    @(negedge clock); in_valid = 1'b0;
    e = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL c2_beat got=%h exp=%h", obs, e); end
    @(negedge clock); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL c2_after got valid=%b rdy=%b exp valid=0 rdy=1", out_valid, in_ready);
    end
    // Case 3: three matches, partial second beat
    drive_pair(16'h0007, 16'h0007);
    @(negedge clock); in_valid = 1'b0;
    e = mk(1, 0, 2, 0, 1, 0, 1, 0, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL c3_beat1 got=%h exp=%h", obs, e); end
    @(negedge clock);
    e = mk(1, 1, 1, 2, 0, 2, 0, 2, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL c3_beat2 got=%h exp=%h", obs, e); end
    @(negedge clock);
  endtask

  task automatic test_backpressure;
    logic [33:0] e1, e2;
    e1 = mk(1, 0, 2, 0, 5, 0, 1, 0, 5);
    e2 = mk(1, 1, 2, 10, 15, 2, 3, 10, 15);
    drive_pair(16'h8421, 16'hFFFF);
    @(negedge clock); in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      out_ready = (c == 3);
      total++;
      if (obs !== e1) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", c, obs, e1); end
      if (c < 3) @(negedge clock);
    end
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_rdy got=%b exp=0", in_ready); end
    @(negedge clock);
    total++;
    if (obs !== e2) begin bad++; $display("FAIL bp_beat2 got=%h exp=%h", obs, e2); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic [33:0] e;
    drive_pair(16'h0003, 16'h0003);
    @(negedge clock);
    in_maskW = 16'h0300; in_maskA = 16'h0300;
    e = mk(1, 1, 2, 0, 1, 0, 1, 0, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_p1 got=%h exp=%h", obs, e); end
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy got=%b exp=1", in_ready); end
    @(negedge clock); in_valid = 1'b0;
    e = mk(1, 1, 2, 8, 9, 0, 1, 0, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_p2 got=%h exp=%h", obs, e); end
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_scan;
    logic [33:0] e;
    drive_pair(16'h8421, 16'hFFFF);
    @(negedge clock); in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 34'h0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid got obs=%h rdy=%b exp obs=0 rdy=0", obs, in_ready);
    end
    @(negedge clock); reset = 1'b0; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || obs !== 34'h0) begin
      bad++; $display("FAIL rst_mid_rel got obs=%h rdy=%b exp obs=0 rdy=1", obs, in_ready);
    end
    drive_pair(16'h0030, 16'h00F0);
    @(negedge clock); in_valid = 1'b0;
    e = mk(1, 1, 2, 4, 5, 0, 1, 0, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL rst_mid_fresh got=%h exp=%h", obs, e); end
    @(negedge clock);
  endtask

  task automatic test_random;
    int n_pairs, sent, cyc, kind;
    logic [33:0] e, prev_obs;
    logic prev_stall, accepted, exp_rdy;
    logic [15:0] x;
    n_pairs = 60; sent = 0; cyc = 0;
    prev_stall = 1'b0; accepted = 1'b0; prev_obs = '0;
    exp_q.delete();
    while ((sent < n_pairs || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clock);
      cyc++;
      total++;
      if (out_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid got=%b exp=%b cyc=%0d", out_valid, exp_q.size() != 0, cyc);
      end
      if (prev_stall) begin
        total++;
        if (obs !== prev_obs) begin bad++; $display("FAIL rnd_hold got=%h exp=%h", obs, prev_obs); end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (accepted) in_valid = 1'b0;
      accepted = 1'b0;
      if (!in_valid && sent < n_pairs && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        kind = $urandom_range(0, 3);
        x = 16'($urandom());
        case (kind)
          0: begin in_maskW = x; in_maskA = 16'($urandom()); end
          1: begin in_maskW = x; in_maskA = x; end
          2: begin in_maskW = x & 16'($urandom()); in_maskA = 16'($urandom()) & 16'($urandom()); end
          default: begin in_maskW = x; in_maskA = ~x; end
        endcase
      end
      #1;
      exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0][32]);
      total++;
      if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_rdy got=%b exp=%b cyc=%0d", in_ready, exp_rdy, cyc); end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h0;
        total++;
        if (obs !== e) begin bad++; $display("FAIL rnd_beat got=%h exp=%h cyc=%0d", obs, e, cyc); end
      end
      if (in_valid && in_ready) begin
        push_model(in_maskW, in_maskA);
        sent++;
        accepted = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
    end
    @(negedge clock);
    in_valid = 1'b0;
    total++;
    if (cyc >= 4000 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rnd_drain got cyc=%0d left=%0d valid=%b exp left=0 valid=0", cyc, exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
